mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit that sits beside the E stage of the 5-stage pipeline.
- Consumes the E-stage operands (the rs/rt values held in the D/E pipeline register) together with an MDU opcode decoded by the E-stage controller.
- Owns the HI/LO registers and models multi-cycle latency through a busy counter.
- Feeds the E/M pipeline register with MFHI/MFLO read data, and gives the hazard logic a busy indication so the D stage can stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  input  1  clock; rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is a valid MDU op this cycle
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  multi-cycle operation in progress
- hi  output  32  current HI register
- lo  output  32  current LO register
- rd  output  32  read data: HI if op=MFHI, LO if op=MFLO, else 0; combinational, independent of start and busy

Behaviour:
- Reset:
  - rst low asynchronously clears HI, LO, busy, the counter and the pending result.
  - A reset mid-operation abandons the operation; no HI/LO update follows.
- Accept condition: start=1, busy=0, op in 1..4 at a rising edge.
  - The full result is computed combinationally and captured into pending HI/LO.
  - counter <= N (MULT_CYCLES or DIV_CYCLES); busy <= 1.
- While busy, each edge decrements counter. On the edge where counter=1:
  - HI <= pending HI, LO <= pending LO, busy <= 0, counter <= 0.
  - Net timing: busy is high for exactly N cycles; HI/LO show the new value in the first cycle busy=0.
- MULT: signed 32x32 -> 64, HI = bits[63:32], LO = bits[31:0]. MULTU: same, unsigned.
- DIV: signed.
  - LO = quotient, truncated toward zero.
  - HI = remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B=0, DIV or DIVU): busy still runs DIV_CYCLES; HI and LO remain unchanged at completion.
- MTHI/MTLO with start=1, busy=0: HI <= A (resp. LO <= A) at that edge; busy is not asserted.
- Any start while busy=1 is ignored entirely: no state change, counter unaffected. The hazard unit stalls D whenever the E-stage op is 1..8 and (busy | start&op in 1..4).
- MFHI/MFLO while busy=1: rd returns the old HI/LO; hazard logic stalls these, and the MDU does not block them.
- start=0 or op NONE/9-15: no state change.
- Back-to-back: a new op is accepted on the same edge busy falls only if start is sampled with busy=0. Therefore the earliest re-accept is the cycle after completion.

Test Plan:
- A=0xFFFFFFFE, B=3, MULT -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- A=0xFFFFFFF9 (-7), B=2, DIV -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 -> LO=3, HI=1. A=0x80000000, B=0xFFFFFFFF, DIV -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge and busy stays 0. With op=MFHI, rd=0x12345678; with op=MFLO, rd=0x9ABCDEF0; with op=NONE, rd=0.
- MULT accepted, then on busy cycle 2 issue DIV and MTLO with start=1 -> both ignored; the MULT completes after exactly 5 cycles with the MULT result, and LO is not overwritten by MTLO.
- HI=1, LO=2 preset; DIV with B=0 -> busy 10 cycles; afterwards HI=1, LO=2.
- DIV accepted, rst pulsed low for part of busy cycle 4 (asynchronous, between edges) -> busy, hi and lo drop to 0 immediately. After release, no HI/LO update ever occurs, and a new MULT is accepted normally.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit beside the E stage: owns HI/LO and holds busy for a
// fixed per-operation latency before committing a precomputed result.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_phi;
    logic [31:0]        r_plo;
    logic               r_pwr;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic [31:0]        w_phi_nxt;
    logic [31:0]        w_plo_nxt;
    logic               w_pwr_nxt;

    logic [63:0]        w_mul_s;
    logic [63:0]        w_mul_u;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_sb;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_div_q;
    logic [31:0]        w_div_r;
    logic [31:0]        w_ub;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign w_mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_mul_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    assign w_a_mag = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag = B[31] ? (~B + 32'd1) : B;
    assign w_sb    = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_sq    = w_a_mag / w_sb;
    assign w_sr    = w_a_mag % w_sb;
    assign w_div_q = (A[31] ^ B[31]) ? (~w_sq + 32'd1) : w_sq;
    assign w_div_r = A[31] ? (~w_sr + 32'd1) : w_sr;

    assign w_ub = (B == 32'd0) ? 32'd1 : B;
    assign w_uq = A / w_ub;
    assign w_ur = A % w_ub;

    // State register and architectural/pending result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_pwr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_pwr   <= w_pwr_nxt;
        end
    end

    // Next-state: accept/move-to in idle, count down and commit while busy
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_pwr_nxt   = r_pwr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            w_phi_nxt   = w_mul_s[63:32];
                            w_plo_nxt   = w_mul_s[31:0];
                            w_pwr_nxt   = 1'b1;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_MULTU: begin
                            w_phi_nxt   = w_mul_u[63:32];
                            w_plo_nxt   = w_mul_u[31:0];
                            w_pwr_nxt   = 1'b1;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_DIV: begin
                            w_phi_nxt   = w_div_r;
                            w_plo_nxt   = w_div_q;
                            w_pwr_nxt   = (B != 32'd0);
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_DIVU: begin
                            w_phi_nxt   = w_ur;
                            w_plo_nxt   = w_uq;
                            w_pwr_nxt   = (B != 32'd0);
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_MTHI: w_hi_nxt = A;
                        OP_MTLO: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    if (r_pwr) begin
                        w_hi_nxt = r_phi;
                        w_lo_nxt = r_plo;
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Move-from read port, deliberately blind to start/busy
    always_comb begin
        rd = 32'd0;
        case (op)
            OP_MFHI: rd = r_hi;
            OP_MFLO: rd = r_lo;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a vector table of single operations followed
// by hand-written interference, divide-by-zero and mid-operation reset cases.
module tb_mdu_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;

    int n_vec;
    int n_fail;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .rd    (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counts busy cycles from the cycle after acceptance, bounded
    task automatic count_busy(input int already, output int cyc);
        cyc = already;
        for (int k = 0; k < 40 && busy; k++) begin
            tick();
            if (busy) cyc++;
        end
    endtask

    task automatic add(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int ec);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp_hi = eh; v.exp_lo = el; v.exp_cyc = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        logic stayed;
        n_vec  = 0;
        n_fail = 0;
        start  = 1'b0;
        op     = 4'd0;
        A      = '0;
        B      = '0;
        rst    = 1'b0;

        add(4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        add(4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5);
        add(4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        add(4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10);
        add(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10);
        add(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5);
        add(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        add(4'd4, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 10);
        add(4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10);
        add(4'd7, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFD, 0);
        add(4'd8, 32'h9ABC_DEF0, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0, 0);
        add(4'd0, 32'h5555_5555, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0, 0);
        add(4'd12, 32'h5555_5555, 32'd1,        32'h1234_5678, 32'h9ABC_DEF0, 0);
        add(4'd5, 32'h5555_5555, 32'd1,         32'h1234_5678, 32'h9ABC_DEF0, 0);
        add(4'd7, 32'd1,         32'd0,         32'd1,         32'h9ABC_DEF0, 0);
        add(4'd8, 32'd2,         32'd0,         32'd1,         32'd2,         0);
        add(4'd3, 32'd5,         32'd0,         32'd1,         32'd2,         10);
        add(4'd4, 32'd9,         32'd0,         32'd1,         32'd2,         10);

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            start = 1'b1; op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            tick();
            start = 1'b0; op = 4'd0;
            if (vecs[i].exp_cyc > 0) begin
                count_busy(busy ? 1 : 0, cyc);
                check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            end else begin
                check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            end
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Read port after HI/LO reload
        start = 1'b1; op = 4'd7; A = 32'h1234_5678; tick();
        op = 4'd8; A = 32'h9ABC_DEF0; tick();
        start = 1'b0;
        op = 4'd5; #1 check("rd_mfhi", rd, 32'h1234_5678);
        op = 4'd6; #1 check("rd_mflo", rd, 32'h9ABC_DEF0);
        op = 4'd0; #1 check("rd_none", rd, 32'd0);
        op = 4'd13; #1 check("rd_op13", rd, 32'd0);

        // Starts during busy are ignored; MULT 3*4 finishes on time
        start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4; tick();
        start = 1'b0; op = 4'd0;
        tick();
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7; tick();
        op = 4'd8; A = 32'hDEAD_BEEF; tick();
        op = 4'd6; #1 check("rd_mflo_busy", rd, 32'h9ABC_DEF0);
        start = 1'b0; op = 4'd0;
        count_busy(4, cyc);
        check("ign_cycles", 32'(cyc), 32'd5);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd12);
        tick();
        check("ign_busy_after", 32'(busy), 32'd0);

        // Asynchronous reset during DIV busy cycle 4
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7; tick();
        start = 1'b0; op = 4'd0;
        tick(); tick(); tick();
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        #1 rst = 1'b1;
        stayed = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy || hi != 32'd0 || lo != 32'd0) stayed = 1'b0;
        end
        check("arst_no_commit", 32'(stayed), 32'd1);
        start = 1'b1; op = 4'd1; A = 32'd6; B = 32'd7; tick();
        start = 1'b0; op = 4'd0;
        count_busy(busy ? 1 : 0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd5);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
